// File: rtl/iir_coef_bank.sv
// Coefficient bank for NUM_STAGES cascaded biquads: byte-wide shadow writes, atomic commit to active outputs.
// Latency: readback 1 cycle after afilter_rd; active set updates on the first sample_strobe after a commit arms.
// Backpressure: none; the bridge port is always ready and an armed commit simply waits for sample_strobe.
module iir_coef_bank #(
  parameter int NUM_STAGES = 2,
  parameter int DEF_RATE   = 7056000,
  parameter int DEF_CX     = 4258969,
  parameter int DEF_CX0    = 3,
  parameter int DEF_CX1    = 3,
  parameter int DEF_CX2    = 1,
  parameter int DEF_CY0    = -6216759,
  parameter int DEF_CY1    = 6143386,
  parameter int DEF_CY2    = -2023767
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     afilter_wr,
  input  logic                     afilter_rd,
  input  logic [7:0]               afilter_addr,
  input  logic [7:0]               afilter_din,
  output logic [7:0]               afilter_dout,
  input  logic                     sample_strobe,
  output logic [31:0]              flt_rate,
  output logic [40*NUM_STAGES-1:0] cx,
  output logic [8*NUM_STAGES-1:0]  cx0,
  output logic [8*NUM_STAGES-1:0]  cx1,
  output logic [8*NUM_STAGES-1:0]  cx2,
  output logic [24*NUM_STAGES-1:0] cy0,
  output logic [24*NUM_STAGES-1:0] cy1,
  output logic [24*NUM_STAGES-1:0] cy2,
  output logic [NUM_STAGES-1:0]    stage_en,
  output logic                     commit_pending,
  output logic                     commit_done
);

  // One stage's coefficient set; kept together so shadow->active is a single struct copy.
  typedef struct packed {
    logic [39:0] cx;
    logic [7:0]  cx0;
    logic [7:0]  cx1;
    logic [7:0]  cx2;
    logic [23:0] cy0;
    logic [23:0] cy1;
    logic [23:0] cy2;
  } coef_t;

  localparam coef_t DEF_COEF = '{
    cx:  40'(DEF_CX),
    cx0: 8'(DEF_CX0),
    cx1: 8'(DEF_CX1),
    cx2: 8'(DEF_CX2),
    cy0: 24'(DEF_CY0),
    cy1: 24'(DEF_CY1),
    cy2: 24'(DEF_CY2)
  };
  localparam logic [31:0]           DEF_RATE_V = 32'(DEF_RATE);
  localparam logic [NUM_STAGES-1:0] DEF_EN     = '1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  coef_t                 sh_coef  [NUM_STAGES];
  coef_t                 act_coef [NUM_STAGES];
  logic [31:0]           sh_rate;
  logic [31:0]           act_rate;
  logic [NUM_STAGES-1:0] sh_en;
  logic [NUM_STAGES-1:0] act_en;

  logic [2:0] addr_stage;
  logic [4:0] addr_off;
  logic       commit_wr;
  logic       copy;
  logic [7:0] rd_byte;

  assign addr_stage = afilter_addr[7:5];
  assign addr_off   = afilter_addr[4:0];
  assign commit_wr  = afilter_wr && (afilter_addr == 8'hFF) && afilter_din[0];

  // Merge one written byte into a stage's coefficient set; unmapped offsets leave it untouched.
  function automatic coef_t coef_wr(input coef_t c, input logic [4:0] off, input logic [7:0] b);
    coef_t r;
    r = c;
    case (off)
      5'h00: r.cx[7:0]    = b;
      5'h01: r.cx[15:8]   = b;
      5'h02: r.cx[23:16]  = b;
      5'h03: r.cx[31:24]  = b;
      5'h04: r.cx[39:32]  = b;
      5'h08: r.cx0        = b;
      5'h09: r.cx1        = b;
      5'h0A: r.cx2        = b;
      5'h0C: r.cy0[7:0]   = b;
      5'h0D: r.cy0[15:8]  = b;
      5'h0E: r.cy0[23:16] = b;
      5'h10: r.cy1[7:0]   = b;
      5'h11: r.cy1[15:8]  = b;
      5'h12: r.cy1[23:16] = b;
      5'h14: r.cy2[7:0]   = b;
      5'h15: r.cy2[15:8]  = b;
      5'h16: r.cy2[23:16] = b;
      default: ;
    endcase
    return r;
  endfunction

  // Extract the byte at a stage offset; holes in the stage map read as zero.
  function automatic logic [7:0] coef_rd(input coef_t c, input logic [4:0] off);
    logic [7:0] r;
    r = 8'h00;
    case (off)
      5'h00: r = c.cx[7:0];
      5'h01: r = c.cx[15:8];
      5'h02: r = c.cx[23:16];
      5'h03: r = c.cx[31:24];
      5'h04: r = c.cx[39:32];
      5'h08: r = c.cx0;
      5'h09: r = c.cx1;
      5'h0A: r = c.cx2;
      5'h0C: r = c.cy0[7:0];
      5'h0D: r = c.cy0[15:8];
      5'h0E: r = c.cy0[23:16];
      5'h10: r = c.cy1[7:0];
      5'h11: r = c.cy1[15:8];
      5'h12: r = c.cy1[23:16];
      5'h14: r = c.cy2[7:0];
      5'h15: r = c.cy2[15:8];
      5'h16: r = c.cy2[23:16];
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Commit state register; reset drops any armed commit.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Commit sequencing: arm on a commit write, copy on the first strobe while armed,
  // and stay armed if a new commit write lands on the copy edge.
  always_comb begin
    state_nxt = state;
    copy      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (commit_wr) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (sample_strobe) begin
          copy = 1'b1;
          if (!commit_wr) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign commit_pending = (state == ST_ARMED);

  // Completion pulse: high for the cycle after the active registers load.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) commit_done <= 1'b0;
    else          commit_done <= copy;
  end

  // Shadow registers: the only state the bridge port can write.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_STAGES; s++) sh_coef[s] <= DEF_COEF;
      sh_rate <= DEF_RATE_V;
      sh_en   <= DEF_EN;
    end else if (afilter_wr) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        if (addr_stage == 3'(s)) sh_coef[s] <= coef_wr(sh_coef[s], addr_off, afilter_din);
      end
      case (afilter_addr)
        8'hF0: sh_rate[7:0]   <= afilter_din;
        8'hF1: sh_rate[15:8]  <= afilter_din;
        8'hF2: sh_rate[23:16] <= afilter_din;
        8'hF3: sh_rate[31:24] <= afilter_din;
        8'hF8: sh_en          <= afilter_din[NUM_STAGES-1:0];
        default: ;
      endcase
    end
  end

  // Active registers: loaded wholesale from the pre-edge shadow values on a copy edge.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_STAGES; s++) act_coef[s] <= DEF_COEF;
      act_rate <= DEF_RATE_V;
      act_en   <= DEF_EN;
    end else if (copy) begin
      for (int s = 0; s < NUM_STAGES; s++) act_coef[s] <= sh_coef[s];
      act_rate <= sh_rate;
      act_en   <= sh_en;
    end
  end

  // Readback mux over shadow state and status; unmapped addresses return zero.
  always_comb begin
    rd_byte = 8'h00;
    for (int s = 0; s < NUM_STAGES; s++) begin
      if (addr_stage == 3'(s)) rd_byte = coef_rd(sh_coef[s], addr_off);
    end
    case (afilter_addr)
      8'hF0: rd_byte = sh_rate[7:0];
      8'hF1: rd_byte = sh_rate[15:8];
      8'hF2: rd_byte = sh_rate[23:16];
      8'hF3: rd_byte = sh_rate[31:24];
      8'hF8: rd_byte = 8'(sh_en);
      8'hFE: rd_byte = {7'b0, commit_pending};
      default: ;
    endcase
  end

  // Registered read data, held until the next read.
  always_ff @(posedge clk_sys) begin
    if (!reset_n)        afilter_dout <= 8'h00;
    else if (afilter_rd) afilter_dout <= rd_byte;
  end

  assign flt_rate = act_rate;
  assign stage_en = act_en;

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_out
    assign cx [s*40 +: 40] = act_coef[s].cx;
    assign cx0[s*8  +: 8]  = act_coef[s].cx0;
    assign cx1[s*8  +: 8]  = act_coef[s].cx1;
    assign cx2[s*8  +: 8]  = act_coef[s].cx2;
    assign cy0[s*24 +: 24] = act_coef[s].cy0;
    assign cy1[s*24 +: 24] = act_coef[s].cy1;
    assign cy2[s*24 +: 24] = act_coef[s].cy2;
  end

endmodule

// File: tb/tb_iir_coef_bank.sv
// Directed bench for iir_coef_bank (NUM_STAGES=2): reset values, shadow writes, commit timing, readback.
// Inputs change and outputs are sampled on the falling edge of clk_sys.
module tb_iir_coef_bank;
  localparam int NS = 2;

  // Default values worked out by hand from the parameter defaults.
  localparam logic [31:0] EXP_RATE = 32'd7056000;   // 0x006BAA80
  localparam logic [39:0] EXP_CX   = 40'd4258969;   // 0x000040FC99
  localparam logic [23:0] EXP_CY0  = 24'd10560457;  // 2^24 - 6216759 = 0xA123C9
  localparam logic [23:0] EXP_CY1  = 24'd6143386;   // 0x5DBD9A
  localparam logic [23:0] EXP_CY2  = 24'd14753449;  // 2^24 - 2023767 = 0xE11EA9

  logic                clk_sys = 1'b0;
  logic                reset_n = 1'b0;
  logic                afilter_wr = 1'b0;
  logic                afilter_rd = 1'b0;
  logic [7:0]          afilter_addr = 8'h00;
  logic [7:0]          afilter_din = 8'h00;
  logic [7:0]          afilter_dout;
  logic                sample_strobe = 1'b0;
  logic [31:0]         flt_rate;
  logic [40*NS-1:0]    cx;
  logic [8*NS-1:0]     cx0, cx1, cx2;
  logic [24*NS-1:0]    cy0, cy1, cy2;
  logic [NS-1:0]       stage_en;
  logic                commit_pending;
  logic                commit_done;

  int n_cmp = 0;
  int n_err = 0;

  iir_coef_bank #(.NUM_STAGES(NS)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .afilter_wr(afilter_wr), .afilter_rd(afilter_rd),
    .afilter_addr(afilter_addr), .afilter_din(afilter_din), .afilter_dout(afilter_dout),
    .sample_strobe(sample_strobe), .flt_rate(flt_rate),
    .cx(cx), .cx0(cx0), .cx1(cx1), .cx2(cx2),
    .cy0(cy0), .cy1(cy1), .cy2(cy2),
    .stage_en(stage_en), .commit_pending(commit_pending), .commit_done(commit_done)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    afilter_wr = 1'b1; afilter_addr = a; afilter_din = d;
    @(negedge clk_sys);
    afilter_wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a);
    @(negedge clk_sys);
    afilter_rd = 1'b1; afilter_addr = a;
    @(negedge clk_sys);
    afilter_rd = 1'b0;
  endtask

  task automatic strobe_pulse();
    @(negedge clk_sys);
    sample_strobe = 1'b1;
    @(negedge clk_sys);
    sample_strobe = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    for (int s = 0; s < NS; s++) begin
      n_cmp++; if (cx[s*40 +: 40] !== EXP_CX) begin n_err++; $display("FAIL reset_cx[%0d]: got %h want %h", s, cx[s*40 +: 40], EXP_CX); end
      n_cmp++; if (cy0[s*24 +: 24] !== EXP_CY0) begin n_err++; $display("FAIL reset_cy0[%0d]: got %h want %h", s, cy0[s*24 +: 24], EXP_CY0); end
      n_cmp++; if ({cx0[s*8 +: 8], cx1[s*8 +: 8], cx2[s*8 +: 8]} !== 24'h030301) begin n_err++; $display("FAIL reset_cxn[%0d]: got %h %h %h want 03 03 01", s, cx0[s*8 +: 8], cx1[s*8 +: 8], cx2[s*8 +: 8]); end
      n_cmp++; if ({cy1[s*24 +: 24], cy2[s*24 +: 24]} !== {EXP_CY1, EXP_CY2}) begin n_err++; $display("FAIL reset_cy12[%0d]: got %h %h want %h %h", s, cy1[s*24 +: 24], cy2[s*24 +: 24], EXP_CY1, EXP_CY2); end
    end
    n_cmp++; if (flt_rate !== EXP_RATE) begin n_err++; $display("FAIL reset_rate: got %0d want %0d", flt_rate, EXP_RATE); end
    n_cmp++; if (stage_en !== 2'b11) begin n_err++; $display("FAIL reset_stage_en: got %b want 11", stage_en); end
    n_cmp++; if ({commit_pending, commit_done} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {commit_pending, commit_done}); end
    n_cmp++; if (afilter_dout !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %h want 00", afilter_dout); end
  endtask

  task automatic test_shadow_write();
    for (int i = 0; i < 5; i++) bus_wr(8'(8'h20 + i), 8'(i + 1));
    bus_rd(8'h22);
    n_cmp++; if (afilter_dout !== 8'h03) begin n_err++; $display("FAIL shadow_rd_22: got %h want 03", afilter_dout); end
    n_cmp++; if (cx[79:40] !== EXP_CX) begin n_err++; $display("FAIL shadow_no_active: got %h want %h", cx[79:40], EXP_CX); end
    repeat (2) @(negedge clk_sys);
    n_cmp++; if (afilter_dout !== 8'h03) begin n_err++; $display("FAIL dout_hold: got %h want 03", afilter_dout); end
  endtask

  task automatic test_commit();
    int hold;
    hold = 0;
    bus_wr(8'hFF, 8'h01);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_sys);
      if (commit_pending === 1'b1) hold++;
    end
    n_cmp++; if (hold !== 10) begin n_err++; $display("FAIL pending_hold: got %0d cycles want 10", hold); end
    n_cmp++; if (cx[79:40] !== EXP_CX) begin n_err++; $display("FAIL commit_early: got %h want %h", cx[79:40], EXP_CX); end
    bus_rd(8'hFE);
    n_cmp++; if (afilter_dout !== 8'h01) begin n_err++; $display("FAIL status_rd: got %h want 01", afilter_dout); end
    strobe_pulse();
    n_cmp++; if (cx[79:40] !== 40'h0504030201) begin n_err++; $display("FAIL commit_cx1: got %h want 0504030201", cx[79:40]); end
    n_cmp++; if ({commit_pending, commit_done} !== 2'b01) begin n_err++; $display("FAIL commit_flags: got %b want 01", {commit_pending, commit_done}); end
    @(negedge clk_sys);
    n_cmp++; if (commit_done !== 1'b0) begin n_err++; $display("FAIL done_width: got %b want 0", commit_done); end
  endtask

  task automatic test_strobe_same_cycle();
    bus_wr(8'h00, 8'hAA);
    @(negedge clk_sys);
    afilter_wr = 1'b1; afilter_addr = 8'hFF; afilter_din = 8'h01; sample_strobe = 1'b1;
    @(negedge clk_sys);
    afilter_wr = 1'b0; sample_strobe = 1'b0;
    n_cmp++; if ({commit_pending, commit_done} !== 2'b10) begin n_err++; $display("FAIL same_cycle_flags: got %b want 10", {commit_pending, commit_done}); end
    n_cmp++; if (cx[39:0] !== EXP_CX) begin n_err++; $display("FAIL same_cycle_nocopy: got %h want %h", cx[39:0], EXP_CX); end
    @(negedge clk_sys);
    afilter_wr = 1'b1; afilter_addr = 8'h0C; afilter_din = 8'h77; sample_strobe = 1'b1;
    @(negedge clk_sys);
    afilter_wr = 1'b0; sample_strobe = 1'b0;
    n_cmp++; if (cx[39:0] !== {EXP_CX[39:8], 8'hAA}) begin n_err++; $display("FAIL copy_cx0: got %h want %h", cx[39:0], {EXP_CX[39:8], 8'hAA}); end
    n_cmp++; if (cy0[23:0] !== EXP_CY0) begin n_err++; $display("FAIL copy_excl_wr: got %h want %h", cy0[23:0], EXP_CY0); end
    n_cmp++; if ({commit_pending, commit_done} !== 2'b01) begin n_err++; $display("FAIL copy_flags: got %b want 01", {commit_pending, commit_done}); end
    bus_rd(8'h0C);
    n_cmp++; if (afilter_dout !== 8'h77) begin n_err++; $display("FAIL shadow_0c: got %h want 77", afilter_dout); end
  endtask

  task automatic test_rearm();
    bus_wr(8'hFF, 8'h01);
    bus_wr(8'hFF, 8'h01);
    bus_wr(8'h01, 8'h55);
    strobe_pulse();
    n_cmp++; if ({commit_pending, commit_done} !== 2'b01) begin n_err++; $display("FAIL double_arm: got %b want 01", {commit_pending, commit_done}); end
    n_cmp++; if (cx[15:8] !== 8'h55) begin n_err++; $display("FAIL double_arm_cx: got %h want 55", cx[15:8]); end
    strobe_pulse();
    n_cmp++; if (commit_done !== 1'b0) begin n_err++; $display("FAIL single_copy: got %b want 0", commit_done); end
    bus_wr(8'hFF, 8'h01);
    @(negedge clk_sys);
    afilter_wr = 1'b1; afilter_addr = 8'hFF; afilter_din = 8'h01; sample_strobe = 1'b1;
    @(negedge clk_sys);
    afilter_wr = 1'b0; sample_strobe = 1'b0;
    n_cmp++; if ({commit_pending, commit_done} !== 2'b11) begin n_err++; $display("FAIL rearm_on_copy: got %b want 11", {commit_pending, commit_done}); end
    strobe_pulse();
    n_cmp++; if ({commit_pending, commit_done} !== 2'b01) begin n_err++; $display("FAIL rearm_second_copy: got %b want 01", {commit_pending, commit_done}); end
    bus_wr(8'hFF, 8'h00);
    n_cmp++; if (commit_pending !== 1'b0) begin n_err++; $display("FAIL commit_din0: got %b want 0", commit_pending); end
  endtask

  task automatic test_stage_en_unmapped();
    bus_wr(8'hF8, 8'hFE);
    bus_rd(8'hF8);
    n_cmp++; if (afilter_dout !== 8'h02) begin n_err++; $display("FAIL stage_en_rd: got %h want 02", afilter_dout); end
    n_cmp++; if (stage_en !== 2'b11) begin n_err++; $display("FAIL stage_en_early: got %b want 11", stage_en); end
    bus_wr(8'hFF, 8'h01);
    strobe_pulse();
    n_cmp++; if (stage_en !== 2'b10) begin n_err++; $display("FAIL stage_en_commit: got %b want 10", stage_en); end
    bus_wr(8'h60, 8'h5A);
    bus_rd(8'h60);
    n_cmp++; if (afilter_dout !== 8'h00) begin n_err++; $display("FAIL unmapped_60: got %h want 00", afilter_dout); end
    @(negedge clk_sys);
    afilter_wr = 1'b1; afilter_rd = 1'b1; afilter_addr = 8'hF0; afilter_din = 8'h11;
    @(negedge clk_sys);
    afilter_wr = 1'b0; afilter_rd = 1'b0;
    n_cmp++; if (afilter_dout !== 8'h80) begin n_err++; $display("FAIL rd_wr_same: got %h want 80", afilter_dout); end
    bus_rd(8'hF0);
    n_cmp++; if (afilter_dout !== 8'h11) begin n_err++; $display("FAIL rate_shadow: got %h want 11", afilter_dout); end
    n_cmp++; if (flt_rate !== EXP_RATE) begin n_err++; $display("FAIL rate_active: got %h want %h", flt_rate, EXP_RATE); end
  endtask

  task automatic test_reset_discard();
    bus_wr(8'hFF, 8'h01);
    @(negedge clk_sys);
    reset_n = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    n_cmp++; if (commit_pending !== 1'b0) begin n_err++; $display("FAIL rst_pending: got %b want 0", commit_pending); end
    strobe_pulse();
    n_cmp++; if (commit_done !== 1'b0) begin n_err++; $display("FAIL rst_no_copy: got %b want 0", commit_done); end
    n_cmp++; if (cx[39:0] !== EXP_CX) begin n_err++; $display("FAIL rst_cx: got %h want %h", cx[39:0], EXP_CX); end
    n_cmp++; if (stage_en !== 2'b11) begin n_err++; $display("FAIL rst_stage_en: got %b want 11", stage_en); end
    n_cmp++; if (flt_rate !== EXP_RATE) begin n_err++; $display("FAIL rst_rate: got %h want %h", flt_rate, EXP_RATE); end
    bus_rd(8'h00);
    n_cmp++; if (afilter_dout !== EXP_CX[7:0]) begin n_err++; $display("FAIL rst_shadow: got %h want %h", afilter_dout, EXP_CX[7:0]); end
  endtask

  initial begin
    test_reset();
    test_shadow_write();
    test_commit();
    test_strobe_same_cycle();
    test_rearm();
    test_stage_en_unmapped();
    test_reset_discard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
